// File: rtl/mesm6_ifetch.sv
// Instruction fetch cache for the mesm6 core: small fully-associative line store,
// half-word opcode select, demand fetch plus optional next-word prefetch, snoop/flush invalidation.
module mesm6_ifetch #(
  parameter int LINES    = 4,
  parameter int ADDR_W   = 15,
  parameter int WORD_W   = 48,
  parameter int PREFETCH = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_W:0]       pc,
  input  logic                  op_req,
  output logic                  op_valid,
  output logic [WORD_W/2-1:0]   opcode,
  input  logic                  flush,
  input  logic                  snoop_we,
  input  logic [ADDR_W-1:0]     snoop_addr,
  output logic                  ibus_fetch,
  output logic [ADDR_W-1:0]     ibus_addr,
  input  logic [WORD_W-1:0]     ibus_input,
  input  logic                  ibus_done,
  output logic [15:0]           miss_count
);

  localparam int IDX_W  = (LINES > 1) ? $clog2(LINES) : 1;
  localparam int HALF_W = WORD_W / 2;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DEMAND = 2'd1,
    S_PREF   = 2'd2
  } state_t;

  state_t              state_q;
  logic                fetch_q;
  logic                taint_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [IDX_W-1:0]    rr_q;
  logic [15:0]         miss_q;
  logic [15:0]         miss_d;
  logic [LINES-1:0]    valid_q;
  logic [LINES-1:0]    valid_d;
  logic [ADDR_W-1:0]   tag_q  [LINES];
  logic [WORD_W-1:0]   data_q [LINES];

  logic [ADDR_W-1:0]   pc_word;
  logic [ADDR_W-1:0]   next_word;
  logic [LINES-1:0]    hit_vec;
  logic [LINES-1:0]    next_vec;
  logic [LINES-1:0]    snoop_vec;
  logic [WORD_W-1:0]   hit_data;
  logic [IDX_W-1:0]    victim;
  logic                hit;
  logic                next_hit;
  logic                snoop_fetch;
  logic                fill;
  logic                demand_miss;

  assign pc_word   = pc[ADDR_W:1];
  assign next_word = pc_word + ADDR_W'(1);

  // Tag match against current pc, the following word, and the snoop address.
  always_comb begin
    hit_data = '0;
    for (int i = 0; i < LINES; i++) begin
      hit_vec[i]   = valid_q[i] && (tag_q[i] == pc_word);
      next_vec[i]  = valid_q[i] && (tag_q[i] == next_word);
      snoop_vec[i] = snoop_we && valid_q[i] && (tag_q[i] == snoop_addr);
      hit_data     = hit_data | ({WORD_W{hit_vec[i]}} & data_q[i]);
    end
  end

  assign hit      = |hit_vec;
  assign next_hit = |next_vec;

  assign op_valid = reset_n & op_req & hit & ~flush;
  assign opcode   = !op_valid ? '0
                  : (pc[0] ? hit_data[HALF_W-1:0] : hit_data[WORD_W-1:HALF_W]);

  // Scanning downward leaves the lowest invalid index; round-robin only when all are valid.
  always_comb begin
    victim = rr_q;
    for (int i = LINES - 1; i >= 0; i--) begin
      victim = valid_q[i] ? victim : IDX_W'(i);
    end
  end

  // A word in flight is dropped if anything invalidated its address meanwhile or on this edge.
  assign snoop_fetch = snoop_we && (snoop_addr == addr_q);
  assign fill        = (state_q != S_IDLE) && ibus_done && !taint_q && !flush && !snoop_fetch;
  assign demand_miss = (state_q == S_IDLE) && op_req && !hit && !flush;
  assign miss_d      = (demand_miss && (miss_q != 16'hFFFF)) ? (miss_q + 16'd1) : miss_q;

  // Valid-bit next state: fill sets the victim, snoop clears matches, flush clears all.
  always_comb begin
    for (int i = 0; i < LINES; i++) begin
      valid_d[i] = !flush &&
                   ((fill && (victim == IDX_W'(i))) || (valid_q[i] && !snoop_vec[i]));
    end
  end

  // Line payload storage; validity is tracked separately so no reset is needed here.
  always_ff @(posedge clk) begin
    if (fill) begin
      tag_q[victim]  <= addr_q;
      data_q[victim] <= ibus_input;
    end
  end

  // Fetch controller, miss counter and replacement pointer.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      fetch_q <= 1'b0;
      taint_q <= 1'b0;
      addr_q  <= '0;
      rr_q    <= '0;
      miss_q  <= 16'd0;
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
      miss_q  <= miss_d;
      case (state_q)
        S_IDLE: begin
          if (demand_miss) begin
            state_q <= S_DEMAND;
            fetch_q <= 1'b1;
            taint_q <= 1'b0;
            addr_q  <= pc_word;
          end else if ((PREFETCH != 0) && op_req && hit && !next_hit && !flush) begin
            state_q <= S_PREF;
            fetch_q <= 1'b1;
            taint_q <= 1'b0;
            addr_q  <= next_word;
          end
        end
        S_DEMAND, S_PREF: begin
          if (ibus_done) begin
            state_q <= S_IDLE;
            fetch_q <= 1'b0;
            taint_q <= 1'b0;
            if (fill) rr_q <= rr_q + IDX_W'(1);
          end else if (flush || snoop_fetch) begin
            taint_q <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          fetch_q <= 1'b0;
          taint_q <= 1'b0;
        end
      endcase
    end
  end

  assign ibus_fetch = fetch_q;
  assign ibus_addr  = addr_q;
  assign miss_count = miss_q;

endmodule

// File: tb/tb_mesm6_ifetch.sv
// Directed bench for mesm6_ifetch: one instance with prefetch, one demand-only
// instance for the replacement scenario.
module tb_mesm6_ifetch;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] pc;
  logic        op_req;
  logic        op_valid;
  logic [23:0] opcode;
  logic        flush;
  logic        snoop_we;
  logic [14:0] snoop_addr;
  logic        ibus_fetch;
  logic [14:0] ibus_addr;
  logic [47:0] ibus_input;
  logic        ibus_done;
  logic [15:0] miss_count;

  logic [15:0] pc_b;
  logic        op_req_b;
  logic        op_valid_b;
  logic [23:0] opcode_b;
  logic        fetch_b;
  logic [14:0] addr_b;
  logic [47:0] input_b;
  logic        done_b;
  logic [15:0] miss_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mesm6_ifetch #(.LINES(4), .ADDR_W(15), .WORD_W(48), .PREFETCH(1)) dut (
    .clk(clk), .reset_n(reset_n), .pc(pc), .op_req(op_req),
    .op_valid(op_valid), .opcode(opcode), .flush(flush),
    .snoop_we(snoop_we), .snoop_addr(snoop_addr),
    .ibus_fetch(ibus_fetch), .ibus_addr(ibus_addr),
    .ibus_input(ibus_input), .ibus_done(ibus_done), .miss_count(miss_count)
  );

  mesm6_ifetch #(.LINES(4), .ADDR_W(15), .WORD_W(48), .PREFETCH(0)) dut_b (
    .clk(clk), .reset_n(reset_n), .pc(pc_b), .op_req(op_req_b),
    .op_valid(op_valid_b), .opcode(opcode_b), .flush(1'b0),
    .snoop_we(1'b0), .snoop_addr(15'h0000),
    .ibus_fetch(fetch_b), .ibus_addr(addr_b),
    .ibus_input(input_b), .ibus_done(done_b), .miss_count(miss_b)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a returning word for one cycle on instance A.
  task automatic serve_a(input logic [47:0] data);
    ibus_input = data;
    ibus_done  = 1'b1;
    step();
    ibus_done  = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; pc = 16'h0000; op_req = 1'b0; flush = 1'b0;
    snoop_we = 1'b0; snoop_addr = 15'h0000; ibus_input = 48'h0; ibus_done = 1'b0;
    pc_b = 16'h0000; op_req_b = 1'b0; input_b = 48'h0; done_b = 1'b0;

    step();
    op_req = 1'b1; pc = 16'h0020;
    step();
    check_eq("rst_fetch", 64'(ibus_fetch), 64'h0);
    check_eq("rst_valid", 64'(op_valid), 64'h0);
    check_eq("rst_opcode", 64'(opcode), 64'h0);
    check_eq("rst_addr", 64'(ibus_addr), 64'h0);
    check_eq("rst_miss", 64'(miss_count), 64'h0);

    // Cold miss
    reset_n = 1'b1;
    #1;
    check_eq("post_rst_fetch", 64'(ibus_fetch), 64'h0);
    check_eq("cold_valid0", 64'(op_valid), 64'h0);
    step();
    check_eq("cold_fetch", 64'(ibus_fetch), 64'h1);
    check_eq("cold_addr", 64'(ibus_addr), 64'h0010);
    check_eq("cold_miss", 64'(miss_count), 64'h1);
    step();
    check_eq("cold_addr_stable", 64'(ibus_addr), 64'h0010);
    serve_a(48'hAAAAAA_555555);
    check_eq("cold_hit", 64'(op_valid), 64'h1);
    check_eq("cold_opc_hi", 64'(opcode), 64'hAAAAAA);
    check_eq("cold_miss1", 64'(miss_count), 64'h1);

    // Prefetch of the next word
    pc = 16'h0021;
    #1;
    check_eq("lo_half", 64'(opcode), 64'h555555);
    step();
    check_eq("pref_fetch", 64'(ibus_fetch), 64'h1);
    check_eq("pref_addr", 64'(ibus_addr), 64'h0011);
    serve_a(48'h111111_222222);
    pc = 16'h0022;
    #1;
    check_eq("pref_hit", 64'(op_valid), 64'h1);
    check_eq("pref_opc", 64'(opcode), 64'h111111);
    check_eq("pref_nomiss", 64'(miss_count), 64'h1);

    // Demand miss while a prefetch is in flight waits for it
    step();
    pc = 16'h0080;
    #1;
    check_eq("pend_valid", 64'(op_valid), 64'h0);
    step();
    check_eq("pend_addr", 64'(ibus_addr), 64'h0012);
    check_eq("pend_miss", 64'(miss_count), 64'h1);
    serve_a(48'h333333_444444);
    check_eq("pend_idle", 64'(ibus_fetch), 64'h0);
    step();
    check_eq("pend_dem_addr", 64'(ibus_addr), 64'h0040);
    check_eq("pend_dem_miss", 64'(miss_count), 64'h2);
    serve_a(48'h404040_414141);
    check_eq("pend_dem_opc", 64'(opcode), 64'h404040);
    op_req = 1'b0;

    // Snoop invalidation, then snoop taint of the refetch
    snoop_we = 1'b1; snoop_addr = 15'h0010;
    step();
    snoop_we = 1'b0; op_req = 1'b1; pc = 16'h0020;
    #1;
    check_eq("snoop_inval", 64'(op_valid), 64'h0);
    step();
    check_eq("snoop_miss", 64'(miss_count), 64'h3);
    check_eq("snoop_addr", 64'(ibus_addr), 64'h0010);
    snoop_we = 1'b1;
    step();
    snoop_we = 1'b0;
    serve_a(48'hDEADBE_EF0123);
    check_eq("taint_discard", 64'(op_valid), 64'h0);
    step();
    check_eq("taint_remiss", 64'(miss_count), 64'h4);
    serve_a(48'hAAAAAA_555555);
    check_eq("taint_refill", 64'(opcode), 64'hAAAAAA);
    op_req = 1'b0;

    // Flush during a demand fetch
    op_req = 1'b1; pc = 16'h0100;
    step();
    check_eq("flush_miss", 64'(miss_count), 64'h5);
    flush = 1'b1;
    step();
    flush = 1'b0;
    serve_a(48'h123456_789ABC);
    pc = 16'h0020;
    #1;
    check_eq("flush_idle", 64'(ibus_fetch), 64'h0);
    check_eq("flush_empty", 64'(op_valid), 64'h0);
    step();
    check_eq("flush_refetch", 64'(ibus_addr), 64'h0010);
    check_eq("flush_remiss", 64'(miss_count), 64'h6);
    serve_a(48'hAAAAAA_555555);
    op_req = 1'b0;

    // Saturating miss counter and prefetch wrap
    force dut.miss_q = 16'hFFFE;
    step();
    release dut.miss_q;
    #1;
    check_eq("sat_preset", 64'(miss_count), 64'hFFFE);
    op_req = 1'b1; pc = 16'hFFFE;
    step();
    check_eq("sat_addr", 64'(ibus_addr), 64'h7FFF);
    check_eq("sat_first", 64'(miss_count), 64'hFFFF);
    serve_a(48'h7F7F7F_FEFEFE);
    check_eq("sat_opc", 64'(opcode), 64'h7F7F7F);
    step();
    check_eq("wrap_fetch", 64'(ibus_fetch), 64'h1);
    check_eq("wrap_addr", 64'(ibus_addr), 64'h0000);
    serve_a(48'h000000_111111);
    pc = 16'h0200;
    step();
    check_eq("sat_hold", 64'(miss_count), 64'hFFFF);
    check_eq("sat_addr2", 64'(ibus_addr), 64'h0100);
    serve_a(48'h0);
    op_req = 1'b0;

    // Replacement on the demand-only instance
    for (int w = 0; w < 5; w++) begin
      pc_b = 16'(w * 2); op_req_b = 1'b1;
      #1;
      check_eq("rep_miss", 64'(op_valid_b), 64'h0);
      step();
      check_eq("rep_addr", 64'(addr_b), 64'(w));
      input_b = {24'(w + 1), 24'h000000};
      done_b = 1'b1;
      step();
      done_b = 1'b0;
      check_eq("rep_opc", 64'(opcode_b), 64'(w + 1));
    end
    check_eq("rep_count5", 64'(miss_b), 64'h5);
    pc_b = 16'h0000;
    #1;
    check_eq("rep_evicted", 64'(op_valid_b), 64'h0);
    step();
    check_eq("rep_count6", 64'(miss_b), 64'h6);
    input_b = 48'h0000AA_000000;
    done_b = 1'b1;
    step();
    done_b = 1'b0;
    check_eq("rep_refill", 64'(opcode_b), 64'h0000AA);
    pc_b = 16'h0002;
    #1;
    check_eq("rep_rr_next", 64'(op_valid_b), 64'h0);
    op_req_b = 1'b0;

    // Reset in the middle of a fetch; the late done must be ignored
    op_req = 1'b1; pc = 16'h0300;
    step();
    check_eq("mid_fetch", 64'(ibus_fetch), 64'h1);
    reset_n = 1'b0; op_req = 1'b0;
    step();
    check_eq("mid_rst_fetch", 64'(ibus_fetch), 64'h0);
    check_eq("mid_rst_miss", 64'(miss_count), 64'h0);
    check_eq("mid_rst_addr", 64'(ibus_addr), 64'h0);
    reset_n = 1'b1;
    serve_a(48'hFFFFFF_FFFFFF);
    check_eq("late_done_idle", 64'(ibus_fetch), 64'h0);
    op_req = 1'b1;
    #1;
    check_eq("late_done_nofill", 64'(op_valid), 64'h0);
    step();
    check_eq("late_done_miss", 64'(miss_count), 64'h1);
    op_req = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
